// File: rtl/calc_input_stage.sv
// calc_input_stage: conditioning front end for the 4-bit signed calculator.
// Synchronises the three active-low pushbuttons and the eight operand switches,
// debounces each key with its own counter, and on every debounced press latches
// an active-low one-hot operation code plus operands A/B for the calculator.
//
// Ports:
//   CLOCK_50  in   system clock, rising edge
//   resetn    in   asynchronous active-low reset
//   key_n     in   [2:0] raw pushbuttons, active-low, asynchronous
//   sw        in   [7:0] raw switches, [7:4] = A, [3:0] = B, asynchronous
//   op_key_n  out  [2:0] captured operation, active-low one-hot, 3'b111 = none
//   a         out  [3:0] captured operand A
//   b         out  [3:0] captured operand B
//   op_valid  out  one-cycle pulse marking a new capture
//   key_down  out  [2:0] debounced key state, active-high
module calc_input_stage #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [2:0] key_n,
  input  logic [7:0] sw,
  output logic [2:0] op_key_n,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       op_valid,
  output logic [2:0] key_down
);

  // Counter only ever needs to reach DEBOUNCE_CYCLES-1, so it can never wrap.
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [2:0]      key_meta_q, ks_q;
  logic [7:0]      sw_meta_q, ss_q;
  logic [2:0]      pressed_q, pressed_d;
  logic [CntW-1:0] cnt_q [3];
  logic [CntW-1:0] cnt_d [3];
  logic [2:0]      press_evt;

  logic [2:0] op_key_n_q, op_key_n_d;
  logic [3:0] a_q, a_d, b_q, b_d;
  logic       op_valid_q, op_valid_d;

  // Two-flop synchronisers; keys idle high, switches idle low.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      key_meta_q <= 3'b111;
      ks_q       <= 3'b111;
      sw_meta_q  <= 8'h00;
      ss_q       <= 8'h00;
    end else begin
      key_meta_q <= key_n;
      ks_q       <= key_meta_q;
      sw_meta_q  <= sw;
      ss_q       <= sw_meta_q;
    end
  end

  // Debounce: count consecutive edges where the synchronised level disagrees
  // with the stable state; any agreeing edge restarts the count.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      pressed_d[i] = pressed_q[i];
      cnt_d[i]     = '0;
      if (!ks_q[i] != pressed_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          pressed_d[i] = ~pressed_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  assign press_evt = pressed_d & ~pressed_q;

  // Capture on the edge a key becomes stable-pressed; highest index wins.
  always_comb begin
    op_key_n_d = op_key_n_q;
    a_d        = a_q;
    b_d        = b_q;
    op_valid_d = 1'b0;
    if (press_evt != 3'b000) begin
      op_valid_d = 1'b1;
      a_d        = ss_q[7:4];
      b_d        = ss_q[3:0];
      if (press_evt[2]) begin
        op_key_n_d = 3'b011;
      end else if (press_evt[1]) begin
        op_key_n_d = 3'b101;
      end else begin
        op_key_n_d = 3'b110;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      pressed_q  <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
      op_key_n_q <= 3'b111;
      a_q        <= 4'h0;
      b_q        <= 4'h0;
      op_valid_q <= 1'b0;
    end else begin
      pressed_q  <= pressed_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      op_key_n_q <= op_key_n_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_valid_q <= op_valid_d;
    end
  end

  assign op_key_n = op_key_n_q;
  assign a        = a_q;
  assign b        = b_q;
  assign op_valid = op_valid_q;
  assign key_down = pressed_q;

endmodule
